generic_payload_fifo: RTL
=========================

Name: generic_payload_fifo

Overview:
- Synchronous FIFO that buffers fixed-width payload words and delivers them, with a valid/ready handshake, to a consumer stage.
- The consumer reads the payload as a packed struct through an input-direction modport. The default payload is two bits, matching a struct with fields a (bit 1) and b (bit 0).
- Sits directly upstream of that consumer. It absorbs producer bursts and backpressure.
- Reports occupancy, an almost-full warning and a sticky protocol-error flag.

Parameters:
- WIDTH, 2, payload width in bits. Must be ≥1.
- DEPTH, 4, number of storage entries. Must be ≥2 and need not be a power of two.
- AFULL_TH, DEPTH-1, occupancy at or above which o_almost_full is asserted. Range 1..DEPTH.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  asynchronous active-low reset.
- i_clear  input  1  synchronous flush; highest priority after reset.
- i_push_valid  input  1  producer offers i_push_data.
- o_push_ready  output  1  FIFO can accept a word this cycle.
- i_push_data  input  WIDTH  producer payload.
- o_pop_valid  output  1  o_pop_data is valid.
- i_pop_ready  input  1  consumer accepts o_pop_data this cycle.
- o_pop_data  output  WIDTH  head-of-queue payload.
- o_count  output  $clog2(DEPTH+1)  current occupancy.
- o_almost_full  output  1  o_count ≥ AFULL_TH.
- o_err  output  1  sticky flag: producer dropped i_push_valid while it was unaccepted.

Behaviour:
- Reset is asynchronous, active-low on i_rst. The clock is i_clk; there is one clock domain.
- Reset values:
  - wr_ptr, rd_ptr and count = 0.
  - o_push_ready = 1, o_pop_valid = 0, o_pop_data = 0, o_count = 0, o_almost_full = 0, o_err = 0.
- Handshakes:
  - push = i_push_valid & o_push_ready.
  - pop = o_pop_valid & i_pop_ready.
  - o_push_ready = (count != DEPTH). It is combinational from registered count only and has no path from i_pop_ready.
- When full, a push is refused even if a pop occurs in the same cycle. The push is accepted the following cycle.
- o_pop_valid = (count != 0). o_pop_data = mem[rd_ptr], combinational from storage (first-word fall-through).
- Write-to-read latency: a word pushed into an empty FIFO at edge N is visible on o_pop_data with o_pop_valid=1 after edge N, i.e. in cycle N+1.
- Pop on empty cannot occur, because pop requires o_pop_valid.
- Pointer wrap: a pointer advances to 0 after DEPTH-1. Explicit compare; no reliance on power-of-two wrap.
- Simultaneous push and pop (neither full nor empty): count unchanged; both pointers advance.
- Simultaneous push and pop with count=1: the old head leaves, the new word becomes head next cycle, and count stays 1.
- count update: count + push - pop.
- o_count mirrors count. o_almost_full = (count ≥ AFULL_TH), registered-state derived.
- i_clear:
  - Sets both pointers and count to 0 on the next edge.
  - Push and pop in that same cycle are ignored.
  - o_err is also cleared.
  - Storage contents are not cleared.
- o_err:
  - Set when, in the previous cycle, i_push_valid=1 and o_push_ready=0, and in the current cycle i_push_valid=0. This detects a valid withdrawn before acceptance.
  - Requires one tracking flop.
  - Held until i_clear or reset.
- A reset asserted mid-burst immediately empties the FIFO. Words in flight are lost and o_pop_valid drops asynchronously.
- Storage is a flop array. No read-enable dependency and no X propagation on the outputs after reset.

Test Plan:
- Reset, then push 0b01, 0b10, 0b11 with i_pop_ready=0 → o_count=3; o_almost_full=1 (AFULL_TH=3); o_pop_data=0b01; o_push_ready=1.
- Push a 4th word 0b00, then hold i_push_valid=1 with 0b11 → o_push_ready=0 and o_count=4. Assert i_pop_ready for one cycle → 0b01 popped; the pending 0b11 is accepted the next cycle; o_count returns to 4.
- Empty FIFO, push 0b10 at edge N → in cycle N+1 o_pop_valid=1 and o_pop_data=0b10. With i_pop_ready=1 and a concurrent push of 0b01 → o_count stays 1 and the head becomes 0b01.
- Stream 10 words 0..3 (mod 4) with push and pop every cycle → output order is identical, there is no bubble after the first word, and pointers wrap twice.
- While full, drop i_push_valid without acceptance → o_err=1 next cycle and it persists. Pulse i_clear → o_err=0, o_count=0, o_pop_valid=0.
- Fill to 3 words, assert i_rst low asynchronously mid-cycle → o_pop_valid=0 and o_count=0 before the next edge. After release, the first push of 0b11 is the first word popped.

Source files
------------

// File: rtl/generic_payload_fifo.sv
// First-word fall-through payload FIFO with valid/ready on both sides,
// occupancy and almost-full reporting, and a sticky producer-withdrawal flag.
module generic_payload_fifo #(
    parameter int WIDTH    = 2,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = DEPTH - 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_clear,
    input  logic                       i_push_valid,
    output logic                       o_push_ready,
    input  logic [WIDTH-1:0]           i_push_data,
    output logic                       o_pop_valid,
    input  logic                       i_pop_ready,
    output logic [WIDTH-1:0]           o_pop_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_almost_full,
    output logic                       o_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PW-1:0] LAST_IDX  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_TH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             stall_q;
    logic             err_q;
    logic             push;
    logic             pop;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Flow-control outputs depend only on registered occupancy, so a full
    // FIFO refuses a push even while a pop is happening in the same cycle.
    assign o_push_ready  = (count != FULL_CNT);
    assign o_pop_valid   = (count != '0);
    assign o_pop_data    = mem[rd_ptr];
    assign o_count       = count;
    assign o_almost_full = (count >= AFULL_CNT);
    assign o_err         = err_q;

    assign push = i_push_valid & o_push_ready & ~i_clear;
    assign pop  = o_pop_valid  & i_pop_ready  & ~i_clear;

    // NOTE: sequential state is always updated with <= so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: storage is reset so o_pop_data is a defined 0 after reset; a flush
    // via i_clear deliberately leaves the contents alone.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= i_push_data;
        end
    end

    // stall_q remembers an offer that was refused last cycle; withdrawing it
    // now is a protocol violation that latches until flush or reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (i_clear) begin
            stall_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= i_push_valid & ~o_push_ready;
            err_q   <= err_q | (stall_q & ~i_push_valid);
        end
    end

endmodule
